conv_viterbi_decoder: RTL and testbench

CONV_VITERBI_DECODER -- requirements
Module: conv_viterbi_decoder

---
 rtl/conv_code_pkg.sv | 36 +++
 rtl/viterbi_acs.sv | 43 ++++
 rtl/conv_viterbi_decoder.sv | 156 +++++++++++++++
 tb/tb_conv_viterbi_decoder.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_code_pkg.sv
// Shared constants for the rate-1/2, K=3 (7,5 octal) convolutional code.
// Used by the Viterbi decoder and by the encoder's checker: generator taps,
// trellis size, decoder FSM encoding, default decoder parameters and the
// symbol / Hamming-distance helpers.
package conv_code_pkg;

    localparam int unsigned NUM_STATES   = 4;
    localparam int unsigned ST_W         = 2;
    localparam int unsigned SYM_W        = 2;
    localparam logic [2:0]  G1           = 3'o7;
    localparam logic [2:0]  G0           = 3'o5;
    localparam int unsigned TB_DEPTH_DEF = 16;
    localparam int unsigned PM_W_DEF     = 6;

    typedef enum logic {
        FILL = 1'b0,
        RUN  = 1'b1
    } fsm_state_t;

    // Expected code symbol {c1,c0} when bit b enters the encoder in 'state'.
    function automatic logic [SYM_W-1:0] enc_symbol(input logic [ST_W-1:0] state,
                                                     input logic            b);
        logic [2:0] taps;
        taps = {b, state};
        return {^(taps & G1), ^(taps & G0)};
    endfunction

    // Hamming distance between two hard-decision symbols (0..2).
    function automatic logic [1:0] hamming(input logic [SYM_W-1:0] a,
                                           input logic [SYM_W-1:0] b);
        logic [SYM_W-1:0] d;
        d = a ^ b;
        return 2'(d[1]) + 2'(d[0]);
    endfunction

endpackage

// File: rtl/viterbi_acs.sv
// Add-compare-select for one trellis state.
// Ports:
//   sym            received hard-decision symbol
//   exp_a, exp_b   expected symbols on the branches from predecessors a (lower
//                  index) and b
//   pm_a, pm_b     current path metrics of the two predecessors
//   surv_a, surv_b current survivors of the two predecessors
//   dec            information bit decided by entering this state
//   pm_c           new (un-normalized) path metric, combinational
//   surv_c         new survivor, combinational
module viterbi_acs
    import conv_code_pkg::*;
#(
    parameter int unsigned PM_W     = PM_W_DEF,
    parameter int unsigned TB_DEPTH = TB_DEPTH_DEF
) (
    input  logic [SYM_W-1:0]    sym,
    input  logic [SYM_W-1:0]    exp_a,
    input  logic [SYM_W-1:0]    exp_b,
    input  logic [PM_W-1:0]     pm_a,
    input  logic [PM_W-1:0]     pm_b,
    input  logic [TB_DEPTH-1:0] surv_a,
    input  logic [TB_DEPTH-1:0] surv_b,
    input  logic                dec,
    output logic [PM_W-1:0]     pm_c,
    output logic [TB_DEPTH-1:0] surv_c
);

    logic [PM_W-1:0] cand_a;
    logic [PM_W-1:0] cand_b;
    logic            pick_b;

    assign cand_a = pm_a + PM_W'(hamming(sym, exp_a));
    assign cand_b = pm_b + PM_W'(hamming(sym, exp_b));

    // Strict compare: a tie keeps the lower-index predecessor.
    assign pick_b = (cand_b < cand_a);
    assign pm_c   = pick_b ? cand_b : cand_a;

    // Shift the decided bit into the chosen survivor; the oldest bit drops out.
    assign surv_c = TB_DEPTH'({(pick_b ? surv_b : surv_a), dec});

endmodule

// File: rtl/conv_viterbi_decoder.sv
// Hard-decision Viterbi decoder for the K=3 (7,5) rate-1/2 code using
// register-exchange survivors.
// Ports:
//   ck          clock, rising edge
//   rset        asynchronous active-high reset
//   cin         received symbol {c1,c0}
//   cin_valid   cin is consumed this cycle
//   bout        decoded information bit (held between valid pulses)
//   bout_valid  one-cycle pulse qualifying bout
//   pm_min      smallest path metric after the latest update
module conv_viterbi_decoder
    import conv_code_pkg::*;
#(
    parameter int unsigned TB_DEPTH = TB_DEPTH_DEF,
    parameter int unsigned PM_W     = PM_W_DEF
) (
    input  logic            ck,
    input  logic            rset,
    input  logic [1:0]      cin,
    input  logic            cin_valid,
    output logic            bout,
    output logic            bout_valid,
    output logic [PM_W-1:0] pm_min
);

    localparam int unsigned      CNT_W     = $clog2(TB_DEPTH);
    localparam logic [CNT_W-1:0] FILL_LAST = CNT_W'(TB_DEPTH - 2);
    localparam logic [PM_W-1:0]  PM_INIT   = PM_W'(2 ** (PM_W - 2));

    logic [PM_W-1:0]     pm_q     [NUM_STATES];
    logic [PM_W-1:0]     pm_acs   [NUM_STATES];
    logic [PM_W-1:0]     pm_norm  [NUM_STATES];
    logic [TB_DEPTH-1:0] surv_q   [NUM_STATES];
    logic [TB_DEPTH-1:0] surv_nxt [NUM_STATES];

    logic                all_msb;
    logic [ST_W-1:0]     min_idx;
    logic [PM_W-1:0]     min_pm;

    fsm_state_t          state_q;
    fsm_state_t          state_d;
    logic [CNT_W-1:0]    cnt_q;
    logic [CNT_W-1:0]    cnt_d;
    logic                bout_d;
    logic                bout_valid_d;

    // New state {b, x} is reached from {x,0} and {x,1}; b is the decided bit.
    for (genvar ns = 0; ns < NUM_STATES; ns++) begin : g_acs
        localparam int unsigned     PA    = 2 * (ns % 2);
        localparam int unsigned     PB    = PA + 1;
        localparam logic            DEC   = 1'(ns / 2);
        localparam logic [SYM_W-1:0] EXP_A = enc_symbol(ST_W'(PA), DEC);
        localparam logic [SYM_W-1:0] EXP_B = enc_symbol(ST_W'(PB), DEC);

        viterbi_acs #(
            .PM_W     (PM_W),
            .TB_DEPTH (TB_DEPTH)
        ) u_acs (
            .sym    (cin),
            .exp_a  (EXP_A),
            .exp_b  (EXP_B),
            .pm_a   (pm_q[PA]),
            .pm_b   (pm_q[PB]),
            .surv_a (surv_q[PA]),
            .surv_b (surv_q[PB]),
            .dec    (DEC),
            .pm_c   (pm_acs[ns]),
            .surv_c (surv_nxt[ns])
        );
    end

    // Metric normalization: subtract 2^(PM_W-1) from all once all have crossed it.
    always_comb begin
        all_msb = 1'b1;
        for (int i = 0; i < NUM_STATES; i++) begin
            all_msb = all_msb & pm_acs[i][PM_W-1];
        end
        for (int i = 0; i < NUM_STATES; i++) begin
            pm_norm[i] = pm_acs[i];
            if (all_msb) begin
                pm_norm[i][PM_W-1] = 1'b0;
            end
        end
    end

    // Best state after this update; lowest index wins a tie.
    always_comb begin
        min_idx = '0;
        min_pm  = pm_norm[0];
        for (int i = 1; i < NUM_STATES; i++) begin
            if (pm_norm[i] < min_pm) begin
                min_idx = ST_W'(i);
                min_pm  = pm_norm[i];
            end
        end
    end

    // FSM state register.
    always_ff @(posedge ck or posedge rset) begin
        if (rset) begin
            state_q <= FILL;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // FSM next state and output decode; count saturates once RUN is entered.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        bout_d       = bout;
        bout_valid_d = 1'b0;
        case (state_q)
            FILL: begin
                if (cin_valid) begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == FILL_LAST) begin
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                if (cin_valid) begin
                    bout_d       = surv_nxt[min_idx][TB_DEPTH-1];
                    bout_valid_d = 1'b1;
                end
            end
        endcase
    end

    // Metrics, survivors and registered outputs.
    always_ff @(posedge ck or posedge rset) begin
        if (rset) begin
            for (int i = 0; i < NUM_STATES; i++) begin
                pm_q[i]   <= (i == 0) ? '0 : PM_INIT;
                surv_q[i] <= '0;
            end
            bout       <= 1'b0;
            bout_valid <= 1'b0;
            pm_min     <= '0;
        end else begin
            bout       <= bout_d;
            bout_valid <= bout_valid_d;
            if (cin_valid) begin
                for (int i = 0; i < NUM_STATES; i++) begin
                    pm_q[i]   <= pm_norm[i];
                    surv_q[i] <= surv_nxt[i];
                end
                pm_min <= min_pm;
            end
        end
    end

endmodule

// File: tb/tb_conv_viterbi_decoder.sv
// Self-checking bench for conv_viterbi_decoder: directed streams plus
// randomized error patterns against a full-path Viterbi reference model with
// unbounded integer metrics.
module tb_conv_viterbi_decoder;

    localparam int unsigned TBD  = 16;
    localparam int unsigned PMW  = 6;
    localparam int          MAXS = 512;

    logic           ck = 1'b0;
    logic           rset;
    logic [1:0]     cin;
    logic           cin_valid;
    logic           bout;
    logic           bout_valid;
    logic [PMW-1:0] pm_min;

    int n_vec = 0;
    int n_err = 0;

    // reference model state
    int  m_pm  [4];
    int  m_off;
    int  m_k;
    bit  m_path[4][MAXS];
    bit  exp_bout;

    bit         info_q[$];
    logic [1:0] sym_q[$];
    bit         dec_q[$];

    conv_viterbi_decoder #(
        .TB_DEPTH (TBD),
        .PM_W     (PMW)
    ) dut (
        .ck         (ck),
        .rset       (rset),
        .cin        (cin),
        .cin_valid  (cin_valid),
        .bout       (bout),
        .bout_valid (bout_valid),
        .pm_min     (pm_min)
    );

    always #5 ck = ~ck;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // encoder: c1 = b^s1^s0, c0 = b^s0, next state {b, s1}
    function automatic bit [1:0] tb_enc(input bit [1:0] st, input bit b);
        return {b ^ st[1] ^ st[0], b ^ st[0]};
    endfunction

    function automatic int ham(input logic [1:0] a, input bit [1:0] b);
        logic [1:0] d;
        d = a ^ b;
        return int'(d[0]) + int'(d[1]);
    endfunction

    task automatic model_reset();
        m_pm[0] = 0;
        for (int i = 1; i < 4; i++) m_pm[i] = 2 ** (PMW - 2);
        m_off = 0;
        m_k   = 0;
    endtask

    function automatic int model_pm_min();
        int mn;
        mn = m_pm[0];
        for (int i = 1; i < 4; i++) if (m_pm[i] < mn) mn = m_pm[i];
        return mn - m_off;
    endfunction

    // One trellis step over full paths, then best-state decision TBD-1 back.
    task automatic model_accept(input logic [1:0] s, output bit v, output bit b);
        int  np [4];
        int  src[4];
        int  best;
        bit  all_hi;
        bit  npath[4][MAXS];
        for (int i = 0; i < 4; i++) begin
            np[i]  = 32'h7fff_ffff;
            src[i] = 0;
        end
        for (int p = 0; p < 4; p++) begin
            for (int bb = 0; bb < 2; bb++) begin
                int nxt;
                int c;
                nxt = bb * 2 + p / 2;
                c   = m_pm[p] + ham(s, tb_enc(2'(p), 1'(bb)));
                if (c < np[nxt]) begin
                    np[nxt]  = c;
                    src[nxt] = p;
                end
            end
        end
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < m_k; j++) npath[i][j] = m_path[src[i]][j];
            npath[i][m_k] = (i >= 2);
        end
        m_path = npath;
        all_hi = 1'b1;
        for (int i = 0; i < 4; i++) if (np[i] - m_off < 2 ** (PMW - 1)) all_hi = 1'b0;
        if (all_hi) m_off += 2 ** (PMW - 1);
        m_pm = np;
        v = 1'b0;
        b = 1'b0;
        if (m_k >= int'(TBD) - 1) begin
            best = 0;
            for (int i = 1; i < 4; i++) if (m_pm[i] < m_pm[best]) best = i;
            v = 1'b1;
            b = m_path[best][m_k - int'(TBD) + 1];
        end
        m_k++;
    endtask

    // Drive one cycle (called at a falling edge), then check at the next falling edge.
    task automatic apply(input bit v, input logic [1:0] s);
        bit ev;
        bit eb;
        cin       = s;
        cin_valid = v;
        @(posedge ck);
        @(negedge ck);
        ev = 1'b0;
        eb = 1'b0;
        if (v) model_accept(s, ev, eb);
        if (ev) begin
            exp_bout = eb;
            dec_q.push_back(eb);
        end
        check_val("bout_valid", bout_valid, ev);
        check_val("bout", bout, exp_bout);
        check_val("pm_min", pm_min, model_pm_min());
        cin_valid = 1'b0;
    endtask

    task automatic do_reset();
        rset      = 1'b1;
        cin_valid = 1'b0;
        @(negedge ck);
        @(negedge ck);
        check_val("rst_bout_valid", bout_valid, 0);
        check_val("rst_bout", bout, 0);
        check_val("rst_pm_min", pm_min, 0);
        rset = 1'b0;
        model_reset();
        exp_bout = 1'b0;
        dec_q.delete();
        @(negedge ck);
    endtask

    task automatic build_stream(input int nflush);
        bit [1:0] st;
        for (int i = 0; i < nflush; i++) info_q.push_back(1'b0);
        sym_q.delete();
        st = 2'b00;
        foreach (info_q[i]) begin
            sym_q.push_back(tb_enc(st, info_q[i]));
            st = {info_q[i], st[1]};
        end
    endtask

    task automatic run_stream(input bit gaps);
        foreach (sym_q[i]) begin
            apply(1'b1, sym_q[i]);
            if (gaps) apply(1'b0, 2'($urandom_range(0, 3)));
        end
    endtask

    // Decoded bits against the transmitted information, independent of the model.
    task automatic verify_decoded(input string tag);
        check_val({tag, "_count"}, dec_q.size(), sym_q.size() - (TBD - 1));
        foreach (dec_q[i]) begin
            if (i < info_q.size()) check_val({tag, "_bit"}, dec_q[i], info_q[i]);
        end
    endtask

    // Random info bits with single-bit symbol errors at least 'gap' symbols apart.
    task automatic random_stream(input int n, input int gap, input int one_in);
        int last;
        info_q.delete();
        for (int i = 0; i < n; i++) info_q.push_back(1'($urandom_range(0, 1)));
        build_stream(TBD + 1);
        last = -100;
        for (int i = 0; i < n; i++) begin
            if ((i - last >= gap) && ($urandom_range(0, one_in - 1) == 0)) begin
                sym_q[i] = sym_q[i] ^ ($urandom_range(0, 1) ? 2'b10 : 2'b01);
                last = i;
            end
        end
    endtask

    initial begin
        rset      = 1'b1;
        cin       = 2'b00;
        cin_valid = 1'b0;
        model_reset();
        exp_bout  = 1'b0;
        @(negedge ck);
        do_reset();

        // error-free reference stream: info 1,0,1,1 then zeros
        info_q = '{1, 0, 1, 1};
        build_stream(16);
        run_stream(1'b0);
        verify_decoded("clean");
        check_val("clean_pm_final", pm_min, 0);

        // same stream, third symbol received as 10
        do_reset();
        info_q = '{1, 0, 1, 1};
        build_stream(16);
        sym_q[2] = 2'b10;
        run_stream(1'b0);
        verify_decoded("one_err");
        check_val("one_err_pm_final", pm_min, 1);

        // same stream with idle cycles between symbols
        do_reset();
        info_q = '{1, 0, 1, 1};
        build_stream(16);
        run_stream(1'b1);
        verify_decoded("gaps");

        // reset after 8 symbols, then a fresh stream
        do_reset();
        random_stream(20, 3, 2);
        for (int i = 0; i < 8; i++) apply(1'b1, sym_q[i]);
        do_reset();
        random_stream(24, 8, 4);
        run_stream(1'b0);
        verify_decoded("after_rst");

        // random errors, about one in ten symbols
        do_reset();
        random_stream(200, 8, 10);
        run_stream(1'b0);
        verify_decoded("rand");

        // dense errors drive metrics through normalization
        do_reset();
        random_stream(320, 8, 1);
        run_stream(1'b0);
        verify_decoded("norm");

        // alternating pattern through the encoder
        do_reset();
        info_q = '{1, 0, 1, 0, 1, 0, 1, 0, 0, 1};
        build_stream(TBD - 1);
        run_stream(1'b0);
        verify_decoded("enc_loop");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
